mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit of the pipelined MIPS core, sitting directly downstream of the register file.
- Consumes the forwarded GPR read operands (rs/rt) and owns the architectural HI/LO registers.
- Implements mult/multu/div/divu/mthi/mtlo with multi-cycle latency, a busy flag for the hazard unit, and a result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy duration of multiply ops, in cycles; legal values are ≥1.
- DIV_CYCLES, 10, busy duration of divide ops, in cycles; legal values are ≥1.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  qualifies op this cycle; E-stage instruction is an MDU op.
- op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7–10 reserved (see Optional Feature).
- A  input  32  rs operand, post-forwarding.
- B  input  32  rt operand, post-forwarding.
- hilo_sel  input  1  0 selects LO, 1 selects HI for mdu_out.
- busy  output  1  high while a mult/div is in flight.
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.
- mdu_out  output  32  hilo_sel ? HI : LO; combinational from the registers.

Behaviour:
- Reset (reset=0, any time, asynchronous):
  - HI, LO ← 0; busy ← 0; counter ← 0; pending results cleared.
  - An in-flight op is aborted and never committed.
- Accept rule: start=1 with busy=0 is accepted at the rising edge. start while busy=1 is ignored with no state change; the hazard unit guarantees a stall, so this never occurs legally.
- MULT/MULTU, accepted at edge T0:
  - {pend_hi, pend_lo} ← 64-bit signed/unsigned product of A, B, captured at T0.
  - Counter ← MULT_CYCLES; busy=1 from T0.
  - Counter decrements each edge. At the edge where counter==1, HI/LO ← pend and busy ← 0, i.e. the new values are visible exactly MULT_CYCLES edges after T0.
- DIV/DIVU: same timing with DIV_CYCLES. LO ← quotient, HI ← remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - B==0: op still runs the full latency and busy toggles normally, but HI/LO are left unchanged at commit.
  - Signed 0x80000000 / 0xFFFFFFFF: LO ← 0x80000000, HI ← 0.
- MTHI/MTLO, accepted with busy=0: HI (or LO) ← A at that same edge; busy stays 0; zero latency.
- op NONE or reserved with start=1: no effect.
- mdu_out, HI and LO always reflect the committed registers, never pending values. During busy they show the pre-op values; the hazard unit stalls mfhi/mflo while busy.
- Back-to-back ops: a new op is accepted at the commit edge only if busy was already 0 in that cycle. The earliest next start is therefore the cycle after busy falls.
- Operands are sampled only at the accept edge; later changes on A/B have no effect.
- Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1.

Optional Feature:
- Macro: MDU_MADD_EN.
- With the macro defined: op codes are added for the multiply-accumulate ops, all with MULT_CYCLES latency and committed at the same edge as MULT.
  - 7 MADD: {HI,LO} += signed A*B.
  - 8 MADDU: {HI,LO} += unsigned A*B.
  - 9 MSUB: {HI,LO} −= signed A*B.
  - 10 MSUBU: {HI,LO} −= unsigned A*B.
  - The accumulate base is the {HI,LO} value at the accept edge. Arithmetic is 64-bit modulo.
- Without the macro: codes 7–10 are reserved no-ops (no busy, no HI/LO change) and no accumulate logic is synthesised.

Test Plan:
- Reset, then accept MULT A=0xFFFFFFFE, B=0x00000003 → busy high for 5 edges; after the 5th edge LO=0xFFFFFFFA, HI=0xFFFFFFFF, busy=0.
- DIV A=0xFFFFFFF9 (−7), B=2 → after 10 edges LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU with the same operands → LO=0x7FFFFFFC, HI=1.
- MTLO A=0x12345678, then MTHI A=0x9ABCDEF0 on consecutive cycles → LO/HI updated on the same edge as each accept. mdu_out follows hilo_sel: 0 gives 0x12345678, 1 gives 0x9ABCDEF0.
- With HI=LO=0x55: DIVU with B=0 → busy high for 10 cycles, HI/LO remain 0x55. A start asserted while busy is ignored.
- MULTU 0xFFFFFFFF×0xFFFFFFFF; drive reset=0 mid-flight at cycle 3 → HI=LO=0 and busy=0 immediately; after reset release no commit occurs.
- MDU_MADD_EN defined: HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 → after 5 edges HI=1, LO=0. Without the macro, the same op code leaves HI/LO unchanged and busy=0.

Source files
------------

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : E-stage MIPS multiply/divide unit owning HI/LO, with fixed
//            multi-cycle latency, busy flag and mfhi/mflo result mux.
//            Optional MADD/MADDU/MSUB/MSUBU ops when MDU_MADD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hilo_sel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] mdu_out
);
    localparam int C_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int C_CNT_W   = $clog2(C_MAX_CYC) + 1;

    localparam logic [3:0] C_OP_MULT  = 4'd1;
    localparam logic [3:0] C_OP_MULTU = 4'd2;
    localparam logic [3:0] C_OP_DIV   = 4'd3;
    localparam logic [3:0] C_OP_DIVU  = 4'd4;
    localparam logic [3:0] C_OP_MTHI  = 4'd5;
    localparam logic [3:0] C_OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] C_OP_MADD  = 4'd7;
    localparam logic [3:0] C_OP_MADDU = 4'd8;
    localparam logic [3:0] C_OP_MSUB  = 4'd9;
    localparam logic [3:0] C_OP_MSUBU = 4'd10;
`endif

    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic               pend_wr_q, pend_wr_d;
    logic               busy_q, busy_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;

    logic [63:0] w_prod_s, w_prod_u;
    logic        w_div_signed, w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag, w_b_safe, w_q_mag, w_r_mag, w_quot, w_rem;

    // Two's-complement low 64 bits of the sign-extended product give the signed result.
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // One unsigned divider serves both DIV and DIVU via sign/magnitude wrapping,
    // which also yields 0x80000000 / -1 = 0x80000000 rem 0 without overflow.
    assign w_div_signed = (op == C_OP_DIV);
    assign w_a_neg      = w_div_signed & A[31];
    assign w_b_neg      = w_div_signed & B[31];
    assign w_a_mag      = w_a_neg ? (32'd0 - A) : A;
    assign w_b_mag      = w_b_neg ? (32'd0 - B) : B;
    assign w_b_safe     = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag      = w_a_mag / w_b_safe;
    assign w_r_mag      = w_a_mag % w_b_safe;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

`ifdef MDU_MADD_EN
    logic [63:0] w_acc_prod, w_acc_res;
    logic        w_acc_sub;
    assign w_acc_prod = (op == C_OP_MADD || op == C_OP_MSUB) ? w_prod_s : w_prod_u;
    assign w_acc_sub  = (op == C_OP_MSUB || op == C_OP_MSUBU);
    assign w_acc_res  = w_acc_sub ? ({hi_q, lo_q} - w_acc_prod) : ({hi_q, lo_q} + w_acc_prod);
`endif

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        if (busy_q) begin
            if (cnt_q == C_CNT_W'(1)) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (pend_wr_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end else begin
                cnt_d = cnt_q - C_CNT_W'(1);
            end
        end else if (start) begin
            case (op)
                C_OP_MULT, C_OP_MULTU: begin
                    {pend_hi_d, pend_lo_d} = (op == C_OP_MULT) ? w_prod_s : w_prod_u;
                    pend_wr_d = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = C_CNT_W'(MULT_CYCLES);
                end
                C_OP_DIV, C_OP_DIVU: begin
                    pend_hi_d = w_rem;
                    pend_lo_d = w_quot;
                    pend_wr_d = (B != 32'd0);
                    busy_d    = 1'b1;
                    cnt_d     = C_CNT_W'(DIV_CYCLES);
                end
                C_OP_MTHI: hi_d = A;
                C_OP_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
                C_OP_MADD, C_OP_MADDU, C_OP_MSUB, C_OP_MSUBU: begin
                    {pend_hi_d, pend_lo_d} = w_acc_res;
                    pend_wr_d = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = C_CNT_W'(MULT_CYCLES);
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy    = busy_q;
    assign HI      = hi_q;
    assign LO      = lo_q;
    assign mdu_out = hilo_sel ? hi_q : lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Self-checking bench for mult_div_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, start, hilo_sel;
    logic [3:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO, mdu_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .hilo_sel(hilo_sel), .busy(busy), .HI(HI), .LO(LO), .mdu_out(mdu_out)
    );

    always #5 clk = ~clk;

    // Reference model: applies an op's architectural effect to m_hi/m_lo and
    // returns how many edges the unit should stay busy.
    task automatic model_op(input logic [3:0] o, input logic [31:0] a,
                            input logic [31:0] b, output int lat);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = $signed(a); sb = $signed(b);
        ua = a;          ub = b;
        lat = 0;
        case (o)
            4'd1: begin p = sa * sb; {m_hi, m_lo} = p; lat = MC; end
            4'd2: begin p = ua * ub; {m_hi, m_lo} = p; lat = MC; end
            4'd3: begin lat = DC; if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end end
            4'd4: begin lat = DC; if (b != 0) begin m_lo = a / b; m_hi = a % b; end end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
`ifdef MDU_MADD_EN
            4'd7:  begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} + p; lat = MC; end
            4'd8:  begin p = ua * ub; {m_hi, m_lo} = {m_hi, m_lo} + p; lat = MC; end
            4'd9:  begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} - p; lat = MC; end
            4'd10: begin p = ua * ub; {m_hi, m_lo} = {m_hi, m_lo} - p; lat = MC; end
`endif
            default: ;
        endcase
    endtask

    // Present an op for one cycle; returns #1 after the accept edge with operands scrambled.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; op = 4'($urandom); A = $urandom; B = $urandom;
    endtask

    task automatic wait_idle(output int edges);
        edges = 0;
        while (busy === 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = 4'd0; A = '0; B = '0; hilo_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_hi = 0; m_lo = 0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", LO); end
        checks++; if (mdu_out !== 32'd0) begin errors++; $display("FAIL reset_out: got %h expected 0", mdu_out); end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_mult();
        int lat, edges;
        logic [31:0] old_hi;
        old_hi = m_hi;
        model_op(4'd1, 32'hFFFFFFFE, 32'h3, lat);
        issue(4'd1, 32'hFFFFFFFE, 32'h3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy: got %b expected 1", busy); end
        checks++; if (HI !== old_hi) begin errors++; $display("FAIL mult_hi_during_busy: got %h expected %h", HI, old_hi); end
        wait_idle(edges);
        checks++; if (edges !== lat) begin errors++; $display("FAIL mult_latency: got %0d expected %0d", edges, lat); end
        checks++; if (LO !== m_lo) begin errors++; $display("FAIL mult_lo: got %h expected %h", LO, m_lo); end
        checks++; if (HI !== m_hi) begin errors++; $display("FAIL mult_hi: got %h expected %h", HI, m_hi); end
    endtask

    task automatic test_div();
        int lat, edges;
        for (int k = 0; k < 3; k++) begin
            logic [3:0]  o;
            logic [31:0] a, b;
            o = (k == 1) ? 4'd4 : 4'd3;
            a = (k == 2) ? 32'h80000000 : 32'hFFFFFFF9;
            b = (k == 2) ? 32'hFFFFFFFF : 32'd2;
            model_op(o, a, b, lat);
            issue(o, a, b);
            wait_idle(edges);
            checks++; if (edges !== lat) begin errors++; $display("FAIL div%0d_latency: got %0d expected %0d", k, edges, lat); end
            checks++; if (LO !== m_lo) begin errors++; $display("FAIL div%0d_lo: got %h expected %h", k, LO, m_lo); end
            checks++; if (HI !== m_hi) begin errors++; $display("FAIL div%0d_hi: got %h expected %h", k, HI, m_hi); end
        end
    endtask

    task automatic test_mtx();
        int lat;
        model_op(4'd6, 32'h12345678, 32'd0, lat);
        issue(4'd6, 32'h12345678, 32'd0);
        checks++; if (LO !== m_lo) begin errors++; $display("FAIL mtlo: got %h expected %h", LO, m_lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b expected 0", busy); end
        model_op(4'd5, 32'h9ABCDEF0, 32'd0, lat);
        issue(4'd5, 32'h9ABCDEF0, 32'd0);
        checks++; if (HI !== m_hi) begin errors++; $display("FAIL mthi: got %h expected %h", HI, m_hi); end
        hilo_sel = 1'b0; #1;
        checks++; if (mdu_out !== m_lo) begin errors++; $display("FAIL mdu_out_lo: got %h expected %h", mdu_out, m_lo); end
        hilo_sel = 1'b1; #1;
        checks++; if (mdu_out !== m_hi) begin errors++; $display("FAIL mdu_out_hi: got %h expected %h", mdu_out, m_hi); end
    endtask

    task automatic test_divzero();
        int lat, edges;
        model_op(4'd5, 32'h55, 32'd0, lat); issue(4'd5, 32'h55, 32'd0);
        model_op(4'd6, 32'h55, 32'd0, lat); issue(4'd6, 32'h55, 32'd0);
        model_op(4'd4, $urandom, 32'd0, lat);
        issue(4'd4, 32'h1234, 32'd0);
        edges = 0;
        // Hammer start with MTLO while busy; every such request must be ignored.
        while (busy === 1'b1 && edges < 100) begin
            start = 1'b1; op = 4'd6; A = $urandom;
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        checks++; if (edges !== lat) begin errors++; $display("FAIL divzero_latency: got %0d expected %0d", edges, lat); end
        checks++; if (HI !== m_hi) begin errors++; $display("FAIL divzero_hi: got %h expected %h", HI, m_hi); end
        checks++; if (LO !== m_lo) begin errors++; $display("FAIL divzero_lo: got %h expected %h", LO, m_lo); end
    endtask

    task automatic test_reset_midflight();
        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0; #1;
        m_hi = 0; m_lo = 0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL midrst_hilo: got %h_%h expected 0_0", HI, LO); end
        @(negedge clk); reset = 1'b1;
        repeat (DC) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_after_busy: got %b expected 0", busy); end
        checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL midrst_no_commit: got %h_%h expected 0_0", HI, LO); end
    endtask

    task automatic test_madd();
        int lat, edges;
        model_op(4'd5, 32'd0, 32'd0, lat);        issue(4'd5, 32'd0, 32'd0);
        model_op(4'd6, 32'hFFFFFFFF, 32'd0, lat); issue(4'd6, 32'hFFFFFFFF, 32'd0);
        model_op(4'd8, 32'd1, 32'd1, lat);
        issue(4'd8, 32'd1, 32'd1);
        wait_idle(edges);
        checks++; if (edges !== lat) begin errors++; $display("FAIL maddu_latency: got %0d expected %0d", edges, lat); end
        checks++; if (HI !== m_hi || LO !== m_lo) begin errors++; $display("FAIL maddu_hilo: got %h_%h expected %h_%h", HI, LO, m_hi, m_lo); end
    endtask

    task automatic test_back_to_back();
        int lat, edges;
        for (int k = 0; k < 3; k++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            model_op(4'd1, a, b, lat);
            issue(4'd1, a, b);
            wait_idle(edges);
            checks++; if (edges !== lat || HI !== m_hi || LO !== m_lo) begin
                errors++; $display("FAIL b2b%0d: got %0d %h_%h expected %0d %h_%h", k, edges, HI, LO, lat, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_random();
        int lat, edges;
        for (int k = 0; k < 60; k++) begin
            logic [3:0]  o;
            logic [31:0] a, b;
            o = 4'($urandom_range(0, 12));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                default: ;
            endcase
            model_op(o, a, b, lat);
            issue(o, a, b);
            wait_idle(edges);
            hilo_sel = 1'($urandom); #1;
            checks++; if (edges !== lat) begin errors++; $display("FAIL rnd%0d_latency op %0d: got %0d expected %0d", k, o, edges, lat); end
            checks++; if (HI !== m_hi) begin errors++; $display("FAIL rnd%0d_hi op %0d a %h b %h: got %h expected %h", k, o, a, b, HI, m_hi); end
            checks++; if (LO !== m_lo) begin errors++; $display("FAIL rnd%0d_lo op %0d a %h b %h: got %h expected %h", k, o, a, b, LO, m_lo); end
            checks++; if (mdu_out !== (hilo_sel ? m_hi : m_lo)) begin
                errors++; $display("FAIL rnd%0d_mdu_out: got %h expected %h", k, mdu_out, hilo_sel ? m_hi : m_lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mtx();
        test_divzero();
        test_reset_midflight();
        test_madd();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
